// File: rtl/reg_exec_sequencer.sv
// Multi-cycle execute sequencer: sole master of a 16x4 register bank.
// Fetches operands over the bank's 1-cycle read port, runs the ALU, writes back.
module reg_exec_sequencer #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4+2*ADDR_W-1:0] instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic                  rb_readEn,
    output logic                  rb_writeEn,
    output logic [ADDR_W-1:0]     rb_addressBus,
    output logic [DATA_W-1:0]     rb_writeData,
    input  logic [DATA_W-1:0]     rb_readData,
    output logic                  done,
    output logic                  illegal_op,
    output logic                  carry_flag,
    output logic                  zero_flag
);

    localparam int IW = 4 + 2*ADDR_W;

    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;

    typedef enum logic [2:0] {IDLE, READ_A, READ_B, EXEC, WB} state_t;

    state_t              state, state_nx;
    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   rd, rs;
    logic [DATA_W-1:0]   op_a, result;
    logic [DATA_W-1:0]   alu_a, alu_b;
    logic [DATA_W:0]     alu_out;
    logic [3:0]          acc_op;
    logic                acc_reads, two_src, one_src, writes, upd_zero, upd_carry;

    // Bit DATA_W carries the ADD carry-out or the SUB borrow.
    function automatic logic [DATA_W:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD, OP_ADDI: alu = {1'b0, a} + {1'b0, b};
            OP_SUB:          alu = {1'b0, a} - {1'b0, b};
            OP_AND:          alu = {1'b0, a & b};
            OP_OR:           alu = {1'b0, a | b};
            OP_XOR:          alu = {1'b0, a ^ b};
            OP_NOT:          alu = {1'b0, ~a};
            default:         alu = {1'b0, b};
        endcase
    endfunction

    assign acc_op    = instr[IW-1 -: 4];
    assign acc_reads = (acc_op >= OP_MOV) && (acc_op <= OP_NOT);
    assign two_src   = (opcode >= OP_MOV) && (opcode <= OP_XOR);
    assign one_src   = (opcode == OP_ADDI) || (opcode == OP_NOT);
    assign writes    = (opcode >= OP_LDI) && (opcode <= OP_NOT);
    assign upd_zero  = (opcode >= OP_ADD) && (opcode <= OP_NOT);
    assign upd_carry = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ADDI);

    // In EXEC the bank is presenting the last operand this very cycle.
    assign alu_a   = one_src ? rb_readData : op_a;
    assign alu_b   = (opcode == OP_ADDI) ? DATA_W'(rs) : rb_readData;
    assign alu_out = alu(opcode, alu_a, alu_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            opcode     <= '0;
            rd         <= '0;
            rs         <= '0;
            op_a       <= '0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        opcode <= acc_op;
                        rd     <= instr[2*ADDR_W-1 -: ADDR_W];
                        rs     <= instr[ADDR_W-1:0];
                    end
                end
                READ_B: op_a <= rb_readData;
                EXEC: begin
                    result <= alu_out[DATA_W-1:0];
                    if (upd_zero)  zero_flag  <= (alu_out[DATA_W-1:0] == '0);
                    if (upd_carry) carry_flag <= alu_out[DATA_W];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        instr_ready   = 1'b0;
        rb_readEn     = 1'b0;
        rb_writeEn    = 1'b0;
        rb_addressBus = '0;
        rb_writeData  = '0;
        done          = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = acc_reads ? READ_A : WB;
            end
            READ_A: begin
                rb_readEn     = 1'b1;
                rb_addressBus = rd;
                state_nx      = two_src ? READ_B : EXEC;
            end
            READ_B: begin
                rb_readEn     = 1'b1;
                rb_addressBus = rs;
                state_nx      = EXEC;
            end
            EXEC: state_nx = WB;
            WB: begin
                done          = 1'b1;
                illegal_op    = (opcode > OP_NOT);
                rb_addressBus = rd;
                if (writes) begin
                    rb_writeEn   = 1'b1;
                    rb_writeData = (opcode == OP_LDI) ? DATA_W'(rs) : result;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_exec_sequencer.sv
// Bench for reg_exec_sequencer: register-bank model, per-cycle architectural
// model comparison, and directed instruction sequences with literal expectations.
module tb_reg_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] instr;
    logic        instr_valid;
    logic        instr_ready, rb_readEn, rb_writeEn;
    logic [3:0]  rb_addressBus, rb_writeData, rb_readData;
    logic        done, illegal_op, carry_flag, zero_flag;

    always #5 clk = ~clk;

    reg_exec_sequencer #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rb_readEn(rb_readEn), .rb_writeEn(rb_writeEn),
        .rb_addressBus(rb_addressBus), .rb_writeData(rb_writeData),
        .rb_readData(rb_readData), .done(done), .illegal_op(illegal_op),
        .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    // Register bank: synchronous write, read data one cycle after readEn.
    logic       bank_clr;
    logic [3:0] bank [16];
    logic [3:0] rd_q;
    assign rb_readData = rd_q;

    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 16; i++) bank[i] <= 4'h0;
            rd_q <= 4'h0;
        end else begin
            if (rb_writeEn) bank[rb_addressBus] <= rb_writeData;
            if (rb_readEn)  rd_q <= bank[rb_addressBus];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Architectural model: one expected bus/flag snapshot per cycle of an instruction.
    typedef struct packed {
        logic       re;
        logic       we;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic       done;
        logic       ill;
        logic       c;
        logic       z;
    } exp_t;

    exp_t       exp_q[$];
    int         arch [16];
    logic       cur_c = 1'b0, cur_z = 1'b0;
    bit         started = 1'b0;
    int         n_acc = 0;
    logic [3:0] last_waddr = 4'h0, last_wdata = 4'h0;

    task automatic push_model(input logic [11:0] ins);
        int op, rd, rs, a, b, r;
        logic nc, nz;
        exp_t e;
        op = int'(ins[11:8]);
        rd = int'(ins[7:4]);
        rs = int'(ins[3:0]);
        a  = arch[rd];
        b  = arch[rs];
        nc = cur_c;
        nz = cur_z;
        case (op)
            1: r = rs;
            2: r = b;
            3: begin r = (a + b) % 16;      nc = (a + b) > 15; end
            4: begin r = (a - b + 16) % 16; nc = (a < b);      end
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: begin r = (a + rs) % 16;     nc = (a + rs) > 15; end
            9: r = 15 - a;
            default: r = 0;
        endcase
        if (op >= 3 && op <= 9) nz = (r == 0);
        if (op >= 2 && op <= 9) begin
            e = '0; e.re = 1'b1; e.addr = 4'(rd); e.c = cur_c; e.z = cur_z;
            exp_q.push_back(e);
        end
        if (op >= 2 && op <= 7) begin
            e = '0; e.re = 1'b1; e.addr = 4'(rs); e.c = cur_c; e.z = cur_z;
            exp_q.push_back(e);
        end
        if (op >= 2 && op <= 9) begin
            e = '0; e.c = cur_c; e.z = cur_z;
            exp_q.push_back(e);
        end
        e = '0;
        e.we    = (op >= 1 && op <= 9);
        e.addr  = 4'(rd);
        e.wdata = e.we ? 4'(r) : 4'h0;
        e.done  = 1'b1;
        e.ill   = (op >= 10);
        e.c     = nc;
        e.z     = nz;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic        ready_x;
        logic [14:0] act, want;
        if (started) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ready_x = 1'b0;
            end else begin
                e = '0; e.c = cur_c; e.z = cur_z;
                ready_x = 1'b1;
            end
            act  = {instr_ready, rb_readEn, rb_writeEn, rb_addressBus,
                    (e.done && !e.we) ? 4'h0 : rb_writeData,
                    done, illegal_op, carry_flag, zero_flag};
            want = {ready_x, e.re, e.we, e.addr, e.wdata, e.done, e.ill, e.c, e.z};
            chk("cycle", {17'd0, act}, {17'd0, want});
            if (e.done) begin
                if (e.we) arch[e.addr] = int'(e.wdata);
                cur_c = e.c;
                cur_z = e.z;
            end
            if (rb_writeEn) begin
                last_waddr = rb_addressBus;
                last_wdata = rb_writeData;
            end
        end
        if (rst) begin
            exp_q.delete();
            cur_c = 1'b0;
            cur_z = 1'b0;
            started = 1'b1;
        end else if (started && instr_valid && instr_ready) begin
            n_acc++;
            push_model(instr);
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue_start(input logic [11:0] ins);
        int w;
        instr = ins;
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("accept_wait", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 12'h0;
    endtask

    task automatic issue(input logic [11:0] ins, output int lat);
        int n;
        issue_start(ins);
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        lat = done ? n : -1;
        if (done) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat;
        int acc0;
        rst = 1'b1; bank_clr = 1'b1; instr = 12'h0; instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; bank_clr = 1'b0;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_outs", {18'd0, rb_readEn, rb_writeEn, rb_addressBus, rb_writeData,
                         done, illegal_op, carry_flag, zero_flag}, 32'd0);

        issue(12'h15A, lat);
        chk("ldi_lat", lat, 1);
        chk("ldi_waddr", last_waddr, 5);
        chk("ldi_wdata", last_wdata, 4'hA);
        chk("ldi_flags", {carry_flag, zero_flag}, 2'b00);
        chk("bank_r5", bank[5], 4'hA);

        issue(12'h119, lat);
        issue(12'h128, lat);
        issue(12'h312, lat);
        chk("add_lat", lat, 4);
        chk("add_wdata", last_wdata, 4'h1);
        chk("add_flags", {carry_flag, zero_flag}, 2'b10);

        issue(12'h134, lat);
        issue(12'h433, lat);
        chk("sub_same_wdata", last_wdata, 4'h0);
        chk("sub_same_flags", {carry_flag, zero_flag}, 2'b01);
        issue(12'h134, lat);
        issue(12'h443, lat);
        chk("sub_borrow_wdata", last_wdata, 4'hC);
        chk("sub_borrow_flags", {carry_flag, zero_flag}, 2'b10);

        issue(12'h827, lat);
        chk("addi_lat", lat, 3);
        chk("addi_wdata", last_wdata, 4'hF);
        chk("addi_flags", {carry_flag, zero_flag}, 2'b00);
        issue(12'h920, lat);
        chk("not_lat", lat, 3);
        chk("not_wdata", last_wdata, 4'h0);
        chk("not_flags", {carry_flag, zero_flag}, 2'b01);

        issue(12'h16F, lat);
        issue(12'h861, lat);
        chk("addi_wrap_flags", {carry_flag, zero_flag}, 2'b11);
        issue(12'h960, lat);
        chk("not_keeps_carry", {carry_flag, zero_flag}, 2'b10);

        issue(12'h285, lat);
        issue(12'h681, lat);
        issue(12'h785, lat);
        issue(12'h586, lat);
        chk("logic_chain_r8", bank[8], 4'h1);
        issue(12'h033, lat);
        chk("nop_lat", lat, 1);

        // Unknown opcode with valid still held through the busy cycle.
        acc0 = n_acc;
        instr = 12'hE77;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        chk("ill_done", {29'd0, done, illegal_op, rb_writeEn}, 32'b110);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 12'h0;
        chk("ill_ready_back", {31'd0, instr_ready}, 32'd1);
        chk("ill_one_accept", n_acc - acc0, 1);
        chk("ill_flags_kept", {carry_flag, zero_flag}, 2'b10);

        // Reset while the ADD is in READ_B.
        issue_start(12'h312);
        @(posedge clk); #1;
        chk("rst_in_read_b", {30'd0, rb_readEn, rb_addressBus == 4'h2}, 32'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_idle", {28'd0, instr_ready, rb_writeEn, carry_flag, zero_flag}, 32'b1000);
        chk("midrst_r1_kept", bank[1], 4'h1);

        issue(12'h193, lat);
        issue(12'h399, lat);
        chk("recover_lat", lat, 4);
        chk("recover_wdata", last_wdata, 4'h6);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) chk("bank_vs_model", bank[i], arch[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
